// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU/MTHI/MTLO, 32-cycle restoring divide.
// Define HILO_MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate operations.
module hilo_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [7:0]  aluop,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic [63:0] hilo,
  output logic        busy
);

  localparam logic [7:0] ALUOP_MTHI  = 8'h11;
  localparam logic [7:0] ALUOP_MTLO  = 8'h13;
  localparam logic [7:0] ALUOP_MULT  = 8'h18;
  localparam logic [7:0] ALUOP_MULTU = 8'h19;
  localparam logic [7:0] ALUOP_DIV   = 8'h1a;
  localparam logic [7:0] ALUOP_DIVU  = 8'h1b;
`ifdef HILO_MDU_MADD_EN
  localparam logic [7:0] ALUOP_MADD  = 8'h1c;
  localparam logic [7:0] ALUOP_MADDU = 8'h1d;
  localparam logic [7:0] ALUOP_MSUB  = 8'h1e;
  localparam logic [7:0] ALUOP_MSUBU = 8'h1f;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    DIV_DONE
  } state_t;

  state_t      state;
  logic [31:0] div_rem;
  logic [31:0] div_quot;
  logic [31:0] div_dvsr;
  logic        neg_q;
  logic        neg_r;
  logic [4:0]  div_cnt;

  logic        issue;
  logic        is_div;
  logic        is_sdiv;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] res_q;
  logic [31:0] res_r;

  assign issue   = valid && !flush && (state == IDLE);
  assign is_div  = (aluop == ALUOP_DIV) || (aluop == ALUOP_DIVU);
  assign is_sdiv = (aluop == ALUOP_DIV);
  assign busy    = !rst && ((issue && is_div) || (!flush && state == DIV_RUN));

  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // The divider core only ever sees magnitudes; signs are reapplied on completion.
  assign abs_a = (is_sdiv && src_a[31]) ? -src_a : src_a;
  assign abs_b = (is_sdiv && src_b[31]) ? -src_b : src_b;

  assign trial = {div_rem, div_quot[31]};
  assign fits  = trial >= {1'b0, div_dvsr};

  assign res_q = neg_q ? -div_quot : div_quot;
  assign res_r = neg_r ? -div_rem : div_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      hilo     <= 64'd0;
      state    <= IDLE;
      div_rem  <= 32'd0;
      div_quot <= 32'd0;
      div_dvsr <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_cnt  <= 5'd0;
    end else if (flush) begin
      state   <= IDLE;
      div_cnt <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            case (aluop)
              ALUOP_MULT:  hilo <= prod_s;
              ALUOP_MULTU: hilo <= prod_u;
              ALUOP_MTHI:  hilo <= {src_a, hilo[31:0]};
              ALUOP_MTLO:  hilo <= {hilo[63:32], src_a};
              ALUOP_DIV, ALUOP_DIVU: begin
                div_rem  <= 32'd0;
                div_quot <= abs_a;
                div_dvsr <= abs_b;
                neg_q    <= is_sdiv && (src_a[31] ^ src_b[31]);
                neg_r    <= is_sdiv && src_a[31];
                div_cnt  <= 5'd0;
                state    <= DIV_RUN;
              end
`ifdef HILO_MDU_MADD_EN
              ALUOP_MADD:  hilo <= hilo + prod_s;
              ALUOP_MADDU: hilo <= hilo + prod_u;
              ALUOP_MSUB:  hilo <= hilo - prod_s;
              ALUOP_MSUBU: hilo <= hilo - prod_u;
`endif
              default: ;
            endcase
          end
        end
        // Dividend shifts out of div_quot MSB first while quotient bits shift in.
        DIV_RUN: begin
          div_rem  <= fits ? (trial[31:0] - div_dvsr) : trial[31:0];
          div_quot <= {div_quot[30:0], fits};
          div_cnt  <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) begin
            state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          hilo  <= {res_r, res_q};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 valid  in  1  E-stage instruction present and not stalled by other hazards.
REQ-004 aluop  in  8  operation code, encodings from defines.vh (ALUOP_MULT/MULTU/DIV/DIVU/MTHI/MTLO/MADD/MADDU/MSUB/MSUBU).
REQ-005 src_a  in  32  rs operand.
REQ-006 src_b  in  32  rt operand.
REQ-007 flush  in  1  pipeline flush (exception/eret); kills E-stage op.
REQ-008 hilo  out  64  architectural {HI,LO}, registered; consumed by M-stage MFHI/MFLO selection.
REQ-009 busy  out  1  stall request to pipeline control; combinational.

Function
REQ-010 Issue condition SHALL be valid & !flush & state==IDLE.
REQ-011 MULT/MULTU: hilo SHALL take the 64-bit signed/unsigned product src_a*src_b at the issue edge; busy stays 0.
REQ-012 MTHI/MTLO: hilo[63:32]/hilo[31:0] SHALL take src_a at the issue edge; other half unchanged.
REQ-013 Any other aluop SHALL leave hilo unchanged.
REQ-014 States SHALL be IDLE, DIV_RUN, DIV_DONE.
REQ-015 DIV/DIVU issue: busy=1 combinationally in the issue cycle; edge captures |src_a|, |src_b| (raw values for DIVU), operand signs, iteration count 0; next state DIV_RUN.
REQ-016 DIV_RUN: busy=1; one restoring-division quotient bit per cycle, MSB first; after 32nd iteration next state DIV_DONE.
REQ-017 Divide latency: busy high for exactly 33 cycles (issue + 32); DIV_DONE cycle busy=0.
REQ-018 DIV_DONE: edge writes HI=remainder, LO=quotient; next state IDLE; valid ignored in DIV_DONE (no re-issue of the held divide).
REQ-019 Signed fixup: quotient negated when operand signs differ; remainder carries dividend sign.
REQ-020 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
REQ-021 Divide by zero: unsigned core result SHALL be used (quotient 0xFFFFFFFF, remainder=|dividend|) then signed fixup per REQ-019; no exception.
REQ-022 flush in any state SHALL force IDLE at the edge, abort any divide, suppress same-cycle issue; hilo unchanged; busy=0 in the flush cycle.
REQ-023 hilo written at the end of the issuing E cycle SHALL be visible to the immediately following instruction's M stage; no bypass path.

Reset
REQ-024 rst SHALL set hilo=0, state=IDLE, iteration count=0; busy=0 during reset cycle.
REQ-025 rst has priority over flush and issue; reset mid-divide discards the divide.

Configuration
REQ-026 Macro HILO_MDU_MADD_EN: when defined, MADD/MADDU SHALL set hilo <= hilo + signed/unsigned product, MSUB/MSUBU hilo <= hilo - product, single cycle, modulo 2^64.
REQ-027 Without HILO_MDU_MADD_EN, those four aluops SHALL behave per REQ-013 and no accumulator adder is built.

Verification
REQ-028 MULT 0xFFFFFFFF x 0x00000002 -> hilo=0xFFFFFFFF_FFFFFFFE next cycle; MULTU same operands -> 0x00000001_FFFFFFFE; busy never high.
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> busy high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFD; DIVU 100/7 -> HI=2, LO=14.
REQ-030 DIVU 5/0 -> HI=5, LO=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> HI=0, LO=0x80000000.
REQ-031 DIV issued, flush at cycle 10 of DIV_RUN -> busy drops same cycle, state IDLE, hilo retains prior value; next MTLO 0x1234 writes normally.
REQ-032 rst asserted mid-divide -> hilo=0, busy=0 next cycle; MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A on consecutive cycles -> hilo=0xA5A5A5A5_5A5A5A5A.
REQ-033 With HILO_MDU_MADD_EN: hilo=0x0_00000010, MSUB 3x7 -> hilo=0xFFFFFFFF_FFFFFFFB; without macro same stimulus leaves hilo=0x10.
